meter_display: RTL and testbench
================================

Name: meter_display

Overview:
- Display-side consumer of the parking-meter time value produced by the button/switch input block.
- Takes the 14-bit binary seconds count and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) converter.
- Multiplexes the digits onto the 4-digit 7-segment display (Basys3-style, active-low).
- Applies the meter's flash policy: fast flashing 0000 at zero, slow flashing below 200, solid at 200 and above.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz)
FLASH_SLOW_HALF, 50000000, cycles per on/off half-period in SLOW mode (0.5 s)
FLASH_FAST_HALF, 25000000, cycles per on/off half-period in FAST mode (0.25 s)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
time_in  input  14  binary seconds remaining from the input block
time_valid  input  1  one-cycle strobe: time_in is new and must be displayed
seg  output  7  segment drive, active-low, seg[6:0] = g,f,e,d,c,b,a
an  output  4  digit anodes, active-low, an[0] = rightmost (ones)
dp  output  1  decimal point, active-low; constant 1 (off)
busy  output  1  high while a BCD conversion is in progress

Behaviour:
- Reset (synchronous, active-high): bcd_disp = 0000, mode = FAST, phase = ON, digit index = 0, refresh and blink counters = 0, pending flag = 0, busy = 0.
- Reset output values: an = 1110, seg = 1000000 ("0"), dp = 1.
- Reset mid-conversion aborts the conversion and discards any pending value.
- Capture: on a posedge with time_valid=1 and busy=0, latch time_in into a 14-bit shift register. Values above 9999 are clamped to 9999. Set busy=1 and clear the BCD accumulator.
- Conversion: 14 iterations, one per clk. On each, add 3 to any accumulator nibble that is >= 5, then shift the accumulator and shift register left by 1.
- Latency: capture at edge N; iterations at edges N+1..N+14; bcd_disp loaded at edge N+15. busy is high from after edge N through edge N+15 and low after N+15.
- The new value is visible on seg at the first digit slot after N+15. Displayed digits never show partial conversion results.
- time_valid while busy=1: store the (clamped) time_in in a pending register and set the pending flag. Later strobes overwrite the pending value (last one wins).
- At the completion edge, if pending=1: clear pending, capture the pending value, and keep busy high. The next conversion starts with no idle cycle.
- Mode is a combinational function of bcd_disp: 0000 → FAST; 0001..0199 → SLOW; >= 0200 → SOLID.
- Blink FSM, states ON and OFF:
  - SOLID: stay in ON, blink counter held at 0.
  - FAST/SLOW: the counter counts to the half-period minus 1, then toggles ON↔OFF and resets to 0.
  - Any mode change (bcd_disp update that changes mode) forces phase = ON and counter = 0 on that edge.
  - A bcd_disp update that keeps the same mode does not disturb the phase or counter.
- Digit multiplexing:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - Active digit anode is low; the other anodes are high.
  - Leading zeros are displayed (e.g. 0045).
  - During the OFF phase, an = 1111. The refresh counter and digit index keep running.
- Segment codes (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles above 9 cannot occur.
- seg, an, and dp are registered outputs (one-cycle delay from the digit index).

Test Plan:
(Bench parameters: REFRESH_DIV=4, FLASH_SLOW_HALF=20, FLASH_FAST_HALF=10.)
- Reset → an=1110, seg=1000000. Across 16 cycles all four digits show "0". Phase toggles to OFF (an=1111) after 10 cycles and back to ON after 10 more.
- time_in=4321 strobe at edge N → busy high for exactly 15 cycles; bcd_disp=4321 at N+15. Digit scan shows an=1110 with "1", 1101 with "2", 1011 with "3", 0111 with "4". No blanking (SOLID).
- time_in=150 → SLOW mode, displays 0150. an=1111 for 20 cycles, then active for 20, repeating. Phase is ON immediately after the update.
- time_in=12000 → displays 9999, SOLID. time_in=16383 also gives 9999.
- Strobe 205, then 10 and 50 while busy → first display 0205. A second conversion runs back-to-back (busy never drops) and ends at 0050. The 10 is never displayed; mode switches SOLID→SLOW with phase reset to ON.
- Assert reset 5 cycles into a conversion of 9999 → after reset, bcd_disp=0000, busy=0, pending cleared. No later update to 9999 occurs.

Source files
------------

// File: rtl/meter_display.sv
// Parking-meter display: 14-bit seconds -> 4 BCD digits (iterative double-dabble),
// multiplexed onto an active-low 4-digit 7-segment display with a mode-dependent flash.
module meter_display #(
    parameter int REFRESH_DIV     = 100000,
    parameter int FLASH_SLOW_HALF = 50000000,
    parameter int FLASH_FAST_HALF = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] time_in,
    input  logic        time_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        busy
);

    localparam int REF_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_MAX = (FLASH_SLOW_HALF > FLASH_FAST_HALF) ? FLASH_SLOW_HALF : FLASH_FAST_HALF;
    localparam int BLINK_W   = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;

    typedef enum logic [1:0] {MODE_FAST, MODE_SLOW, MODE_SOLID} mode_t;
    typedef enum logic {PH_ON, PH_OFF} phase_t;

    function automatic mode_t mode_of(input logic [15:0] bcd);
        if (bcd == 16'h0000) return MODE_FAST;
        if (bcd[15:12] == 4'd0 && bcd[11:8] < 4'd2) return MODE_SLOW;
        return MODE_SOLID;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    logic [13:0]        sh_q, sh_d;
    logic [15:0]        acc_q, acc_d, acc_adj;
    logic [3:0]         iter_q, iter_d;
    logic               busy_q, busy_d;
    logic [13:0]        pend_val_q, pend_val_d;
    logic               pend_q, pend_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [13:0]        tin_clamped;

    phase_t             phase_q, phase_d;
    logic [BLINK_W-1:0] blink_q, blink_d, half_m1;
    mode_t              mode_cur, mode_nxt;

    logic [REF_W-1:0]   ref_q, ref_d;
    logic [1:0]         dig_q, dig_d;
    logic [3:0]         nib;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               dp_q;

    assign tin_clamped = (time_in > 14'd9999) ? 14'd9999 : time_in;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                                   : acc_q[gi*4 +: 4];
        end
    endgenerate

    // Converter: idle -> 14 shift iterations -> completion edge that publishes the
    // result and immediately restarts if a newer value arrived meanwhile.
    always_comb begin
        sh_d       = sh_q;
        acc_d      = acc_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        bcd_d      = bcd_q;
        if (!busy_q) begin
            if (time_valid) begin
                sh_d   = tin_clamped;
                acc_d  = 16'h0000;
                iter_d = 4'd0;
                busy_d = 1'b1;
            end
        end else if (iter_q != 4'd14) begin
            {acc_d, sh_d} = {acc_adj, sh_q} << 1;
            iter_d        = iter_q + 4'd1;
            if (time_valid) begin
                pend_val_d = tin_clamped;
                pend_d     = 1'b1;
            end
        end else begin
            bcd_d  = acc_q;
            acc_d  = 16'h0000;
            iter_d = 4'd0;
            pend_d = 1'b0;
            if (time_valid) begin
                sh_d = tin_clamped;
            end else if (pend_q) begin
                sh_d = pend_val_q;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    assign mode_cur = mode_of(bcd_q);
    assign mode_nxt = mode_of(bcd_d);
    assign half_m1  = (mode_cur == MODE_FAST) ? BLINK_W'(FLASH_FAST_HALF - 1)
                                              : BLINK_W'(FLASH_SLOW_HALF - 1);

    always_comb begin
        phase_d = phase_q;
        blink_d = blink_q;
        if (mode_nxt != mode_cur || mode_cur == MODE_SOLID) begin
            phase_d = PH_ON;
            blink_d = '0;
        end else if (blink_q == half_m1) begin
            phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            blink_d = '0;
        end else begin
            blink_d = blink_q + 1'b1;
        end
    end

    // Digit scan keeps running while blanked so the flash never skews the refresh.
    always_comb begin
        ref_d = ref_q + 1'b1;
        dig_d = dig_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            dig_d = dig_q + 2'd1;
        end
    end

    assign nib  = bcd_q[{dig_q, 2'b00} +: 4];
    assign seg_d = seg_code(nib);
    assign an_d  = (phase_q == PH_OFF) ? 4'b1111 : ~(4'b0001 << dig_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q       <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            bcd_q      <= 16'h0000;
            phase_q    <= PH_ON;
            blink_q    <= '0;
            ref_q      <= '0;
            dig_q      <= '0;
            seg_q      <= 7'b1000000;
            an_q       <= 4'b1110;
            dp_q       <= 1'b1;
        end else begin
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            bcd_q      <= bcd_d;
            phase_q    <= phase_d;
            blink_q    <= blink_d;
            ref_q      <= ref_d;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= 1'b1;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_meter_display.sv
// Directed bench for meter_display with shortened refresh/flash periods.
module tb_meter_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] time_in = '0;
    logic        time_valid = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Window statistics gathered while watching the display
    int w_n, w_blank, w_bad_seg, w_bad_an, w_busy, w_dp_bad, w_first_blank;
    logic [3:0] w_seen;

    typedef struct {
        logic [13:0] tin;
        logic [15:0] bcd;
        int          blanks;
    } vec_t;

    vec_t vecs[8];

    meter_display #(
        .REFRESH_DIV(4),
        .FLASH_SLOW_HALF(20),
        .FLASH_FAST_HALF(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .time_in(time_in),
        .time_valid(time_valid),
        .seg(seg),
        .an(an),
        .dp(dp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic win_clear();
        w_n = 0; w_blank = 0; w_bad_seg = 0; w_bad_an = 0;
        w_busy = 0; w_dp_bad = 0; w_first_blank = 0; w_seen = 4'b0000;
    endtask

    task automatic win_sample(input logic [15:0] bcd);
        int idx;
        idx = -1;
        if (busy) w_busy++;
        if (dp !== 1'b1) w_dp_bad++;
        case (an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            4'b1111: idx = -1;
            default: w_bad_an++;
        endcase
        if (an == 4'b1111) begin
            w_blank++;
            if (w_n == 0) w_first_blank = 1;
        end else if (idx >= 0) begin
            w_seen[idx] = 1'b1;
            if (seg !== exp_seg(bcd[idx*4 +: 4])) w_bad_seg++;
        end
        w_n++;
    endtask

    task automatic win_checks(input string name, input int blanks);
        check({name, "_bad_seg"}, w_bad_seg, 0);
        check({name, "_bad_an"}, w_bad_an, 0);
        check({name, "_blanks"}, w_blank, blanks);
        check({name, "_first_on"}, w_first_blank, 0);
        check({name, "_busy_idle"}, w_busy, 0);
        check({name, "_dp"}, w_dp_bad, 0);
        if (blanks == 0) check({name, "_digits_seen"}, int'(w_seen), 15);
    endtask

    task automatic watch(input string name, input logic [15:0] bcd, input int blanks);
        win_clear();
        for (int i = 0; i < 40; i++) begin
            tick();
            win_sample(bcd);
        end
        win_checks(name, blanks);
    endtask

    task automatic strobe(input logic [13:0] v);
        time_in = v;
        time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
    endtask

    task automatic busy_len(input string name, input int exp);
        int k;
        k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        check({name, "_busy_cycles"}, k, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{14'd4321,  16'h4321, 0};
        vecs[1] = '{14'd150,   16'h0150, 20};
        vecs[2] = '{14'd12000, 16'h9999, 0};
        vecs[3] = '{14'd16383, 16'h9999, 0};
        vecs[4] = '{14'd0,     16'h0000, 20};
        vecs[5] = '{14'd199,   16'h0199, 20};
        vecs[6] = '{14'd200,   16'h0200, 0};
        vecs[7] = '{14'd10000, 16'h9999, 0};

        tick();
        do_reset();
        check("rst_an", int'(an), int'(4'b1110));
        check("rst_seg", int'(seg), int'(7'b1000000));
        check("rst_dp", int'(dp), 1);
        check("rst_busy", int'(busy), 0);

        // Idle FAST flash of 0000: blanked for samples 11..20 after reset
        for (int j = 1; j <= 30; j++) begin
            logic [3:0] ea;
            tick();
            if (j >= 11 && j <= 20) ea = 4'b1111;
            else ea = ~(4'b0001 << (((j - 1) / 4) % 4));
            check($sformatf("idle_an_%0d", j), int'(an), int'(ea));
            if (ea != 4'b1111) check($sformatf("idle_seg_%0d", j), int'(seg), int'(7'b1000000));
        end

        for (int v = 0; v < 8; v++) begin
            string nm;
            nm = $sformatf("vec%0d_%0d", v, vecs[v].tin);
            strobe(vecs[v].tin);
            busy_len(nm, 15);
            watch(nm, vecs[v].bcd, vecs[v].blanks);
            $display("vector %0d time_in=%0d expect=%04h blanks=%0d", v, vecs[v].tin, vecs[v].bcd, vecs[v].blanks);
        end

        // Back-to-back: 205 converts, 10 is overwritten by 50, 50 follows with no idle cycle
        begin
            int busy_low;
            busy_low = 0;
            strobe(14'd205);
            win_clear();
            for (int i = 1; i <= 30; i++) begin
                time_valid = 1'b0;
                if (i == 2) begin time_in = 14'd10; time_valid = 1'b1; end
                if (i == 4) begin time_in = 14'd50; time_valid = 1'b1; end
                tick();
                time_valid = 1'b0;
                if (i < 30 && !busy) busy_low++;
                if (i >= 16) win_sample(16'h0205);
            end
            check("b2b_busy_low_cycles", busy_low, 0);
            check("b2b_busy_end", int'(busy), 0);
            check("b2b_0205_bad_seg", w_bad_seg, 0);
            check("b2b_0205_blanks", w_blank, 0);
            check("b2b_0205_bad_an", w_bad_an, 0);
            watch("b2b_0050", 16'h0050, 20);
            $display("back-to-back 205/10/50 done");
        end

        // Reset 5 cycles into a conversion with a pending value queued
        strobe(14'd9999);
        time_in = 14'd3333;
        time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        check("midrst_busy", int'(busy), 0);
        check("midrst_an", int'(an), int'(4'b1110));
        check("midrst_seg", int'(seg), int'(7'b1000000));
        watch("midrst_idle", 16'h0000, 20);
        strobe(14'd7);
        busy_len("post_rst_7", 15);
        watch("post_rst_7", 16'h0007, 20);
        $display("mid-conversion reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
